// File: rtl/booth_operand_sequencer.sv
// booth_operand_sequencer
// Buffers signed operand pairs in a small FIFO and feeds them one at a time
// to a 16-bit sequential Booth multiplier over its shared load bus
// (start / multiplicand / multiplier). It then waits for done, captures the
// product and hands it downstream over a valid/ready port.
// Optional feature: define BOOTH_SEQ_TIMEOUT_EN to bound the wait for mul_done
// to TIMEOUT cycles. A timeout reports out_err=1 with a zero product.

package booth_operand_sequencer_pkg;

    localparam int unsigned OP_W   = 16;
    localparam int unsigned PROD_W = 32;
    localparam int unsigned WCNT_W = 6;

    // One buffered operand pair
    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } operand_pair_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_LD_M  = 3'd2,
        ST_LD_Q  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_RESP  = 3'd5,
        ST_CLR   = 3'd6
    } seq_state_t;

endpackage

module booth_operand_sequencer
    import booth_operand_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned TIMEOUT = 40
) (
    input  logic              clk,
    input  logic              rst_n,
    // operand stream
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    // product stream
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_product,
    output logic              out_err,
    // multiplier side
    output logic              mul_start,
    output logic [OP_W-1:0]   mul_data,
    input  logic              mul_done,
    input  logic [PROD_W-1:0] mul_product,
    output logic              mul_clr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    // Reject configurations the FIFO and wait counter cannot represent
    if ((DEPTH < 2) || (DEPTH > 8) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("booth_operand_sequencer: DEPTH must be a power of two in 2..8");
    end
    if ((TIMEOUT < 1) || (TIMEOUT > ((2 ** WCNT_W) - 1))) begin : g_bad_timeout
        $error("booth_operand_sequencer: TIMEOUT must fit the 6-bit wait counter");
    end

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    seq_state_t        r_state;
    seq_state_t        w_state_nxt;

    operand_pair_t     r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     w_wr_ptr_nxt;
    logic [PW-1:0]     w_rd_ptr_nxt;
    logic              r_in_ready;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic              w_full_nxt;
    operand_pair_t     w_head;
    operand_pair_t     w_in_pair;

    operand_pair_t     r_op;

    logic              w_timeout;

    logic              r_mul_start;
    logic              r_mul_clr;
    logic [OP_W-1:0]   r_mul_data;
    logic              r_out_valid;
    logic [PROD_W-1:0] r_out_product;
    logic              r_out_err;

    logic              w_mul_start_nxt;
    logic              w_mul_clr_nxt;
    logic [OP_W-1:0]   w_mul_data_nxt;
    logic              w_out_valid_nxt;
    logic [PROD_W-1:0] w_out_product_nxt;
    logic              w_out_err_nxt;

    // ------------------------------------------------------------------
    // Operand FIFO
    // ------------------------------------------------------------------
    assign w_in_pair    = '{a: in_a, b: in_b};
    assign w_push       = in_valid && r_in_ready;
    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_pop        = (r_state == ST_IDLE) && !w_empty && !r_out_valid;
    assign w_head       = r_mem[r_rd_ptr[AW-1:0]];
    assign w_wr_ptr_nxt = r_wr_ptr + PW'(w_push);
    assign w_rd_ptr_nxt = r_rd_ptr + PW'(w_pop);

    // Full when the lap bits differ and the index bits match
    assign w_full_nxt = (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]) &&
                        (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]);

    // Pointer update; in_ready tracks the occupancy the pointers will hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_in_ready <= 1'b1;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_in_ready <= !w_full_nxt;
        end
    end

    // FIFO storage write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_in_pair;
        end
    end

    // Latch the head pair as the FSM leaves IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op <= '0;
        end else if (w_pop) begin
            r_op <= w_head;
        end
    end

    // ------------------------------------------------------------------
    // Optional bounded wait for mul_done
    // ------------------------------------------------------------------
`ifdef BOOTH_SEQ_TIMEOUT_EN
    logic [WCNT_W-1:0] r_wait_cnt;

    // Counts WAIT cycles; zero on the first WAIT cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (r_state != ST_WAIT) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
        end
    end

    // Fires on the WAIT cycle whose edge brings the count to TIMEOUT
    assign w_timeout = (r_state == ST_WAIT) && !mul_done &&
                       (r_wait_cnt == WCNT_W'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pop) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: w_state_nxt = ST_LD_M;
            ST_LD_M:  w_state_nxt = ST_LD_Q;
            ST_LD_Q:  w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (mul_done || w_timeout) begin
                    w_state_nxt = ST_CLR;
                end
            end
            ST_CLR:   w_state_nxt = ST_RESP;
            ST_RESP: begin
                if (r_out_valid && out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: bus/strobe values for the state being entered,
    // result capture for the state being left
    always_comb begin
        w_mul_start_nxt   = 1'b0;
        w_mul_clr_nxt     = 1'b0;
        w_mul_data_nxt    = '0;
        w_out_valid_nxt   = r_out_valid;
        w_out_product_nxt = r_out_product;
        w_out_err_nxt     = r_out_err;

        case (w_state_nxt)
            ST_START: w_mul_start_nxt = 1'b1;
            ST_LD_M:  w_mul_data_nxt  = r_op.a;
            ST_LD_Q:  w_mul_data_nxt  = r_op.b;
            ST_CLR:   w_mul_clr_nxt   = 1'b1;
            default:  ;
        endcase

        case (r_state)
            ST_WAIT: begin
                if (mul_done) begin
                    w_out_product_nxt = mul_product;
                end else if (w_timeout) begin
                    w_out_product_nxt = '0;
                    w_out_err_nxt     = 1'b1;
                end
            end
            ST_CLR: begin
                w_out_valid_nxt = 1'b1;
            end
            ST_RESP: begin
                if (r_out_valid && out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_out_err_nxt   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mul_start   <= 1'b0;
            r_mul_clr     <= 1'b0;
            r_mul_data    <= '0;
            r_out_valid   <= 1'b0;
            r_out_product <= '0;
            r_out_err     <= 1'b0;
        end else begin
            r_mul_start   <= w_mul_start_nxt;
            r_mul_clr     <= w_mul_clr_nxt;
            r_mul_data    <= w_mul_data_nxt;
            r_out_valid   <= w_out_valid_nxt;
            r_out_product <= w_out_product_nxt;
            r_out_err     <= w_out_err_nxt;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_product = r_out_product;
    assign out_err     = r_out_err;
    assign mul_start   = r_mul_start;
    assign mul_data    = r_mul_data;
    assign mul_clr     = r_mul_clr;

endmodule

// File: tb/tb_booth_operand_sequencer.sv
// Directed bench for booth_operand_sequencer with a behavioural Booth
// multiplier responder. The timeout scenario is built only when
// BOOTH_SEQ_TIMEOUT_EN is defined.

module tb_booth_operand_sequencer;

    localparam int unsigned DEPTH   = 2;
    localparam int unsigned TIMEOUT = 40;
    localparam int unsigned N_WAIT  = 6;                  // WAIT cycles per op with this responder
    localparam int unsigned LAT     = 1 + 3 + N_WAIT + 1; // push edge to out_valid

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_product;
    logic        out_err;
    logic        mul_start;
    logic [15:0] mul_data;
    logic        mul_done;
    logic [31:0] mul_product;
    logic        mul_clr;

    always #5 clk = ~clk;

    booth_operand_sequencer #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .out_err     (out_err),
        .mul_start   (mul_start),
        .mul_data    (mul_data),
        .mul_done    (mul_done),
        .mul_product (mul_product),
        .mul_clr     (mul_clr)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Behavioural multiplier: start, then multiplicand, then multiplier on
    // consecutive edges; done rises after a fixed delay and holds until clr
    int          m_phase;
    int          m_cnt;
    int          m_proto_err = 0;
    bit          m_hang = 1'b0;
    logic [15:0] m_start_data;
    logic [15:0] m_ld_m;
    logic [15:0] m_ld_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase     <= 0;
            m_cnt       <= 0;
            mul_done    <= 1'b0;
            mul_product <= '0;
        end else if (mul_clr) begin
            m_phase  <= 0;
            mul_done <= 1'b0;
        end else begin
            if (mul_start && m_phase != 0) m_proto_err <= m_proto_err + 1;
            case (m_phase)
                0: if (mul_start) begin
                    m_start_data <= mul_data;
                    m_phase      <= 1;
                end
                1: begin
                    m_ld_m  <= mul_data;
                    m_phase <= 2;
                end
                2: begin
                    m_ld_q  <= mul_data;
                    m_cnt   <= 0;
                    m_phase <= 3;
                end
                3: if (!m_hang) begin
                    if (m_cnt == int'(N_WAIT) - 2) begin
                        mul_done    <= 1'b1;
                        mul_product <= 32'(int'($signed(m_ld_m)) * int'($signed(m_ld_q)));
                        m_phase     <= 4;
                    end else begin
                        m_cnt <= m_cnt + 1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobe counters and result collection
    int          n_clr = 0;
    int          n_start = 0;
    logic [31:0] got_q[$];

    always @(posedge clk) begin
        if (mul_clr)   n_clr   <= n_clr + 1;
        if (mul_start) n_start <= n_start + 1;
        if (rst_n && out_valid && out_ready) got_q.push_back(out_product);
    end

    // FIFO occupancy model: +1 per accepted push, -1 per pop (start follows pop)
    bit chk_occ = 1'b0;
    int occ = 0;
    int n_ready_low = 0;

    initial begin : occ_model
        bit pend_push;
        bit prev_start;
        pend_push  = 1'b0;
        prev_start = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                occ        = 0;
                pend_push  = 1'b0;
                prev_start = 1'b0;
            end else begin
                if (pend_push) occ++;
                if (mul_start && !prev_start) occ--;
                if (chk_occ) begin
                    check($sformatf("in_ready_vs_occ%0d", occ), 32'(in_ready), 32'(occ != int'(DEPTH)));
                    if (!in_ready) n_ready_low++;
                end
                pend_push  = in_valid && in_ready;
                prev_start = mul_start;
            end
        end
    end

    // Offer one pair (called #1 after an edge); returns #1 after acceptance
    task automatic push(input logic [15:0] a, input logic [15:0] b);
        int t;
        t        = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!in_ready && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 300) check("push_wait_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait for out_valid from #1 after the push edge; returns edges elapsed
    task automatic wait_result(input int limit, output int lat);
        lat = 0;
        while (!out_valid && lat < limit) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    vec_t vecs[8];
    vec_t fv[4];
    vec_t bp[2];

    initial begin
        int lat;
        int clr0;
        int bad;
        int stale;

        vecs[0] = '{a: 16'h0003, b: 16'hFFFB, p: 32'hFFFF_FFF1};
        vecs[1] = '{a: 16'h8000, b: 16'h8000, p: 32'h4000_0000};
        vecs[2] = '{a: 16'h7FFF, b: 16'hFFFF, p: 32'hFFFF_8001};
        vecs[3] = '{a: 16'h0000, b: 16'h04D2, p: 32'h0000_0000};
        vecs[4] = '{a: 16'hFFFF, b: 16'hFFFF, p: 32'h0000_0001};
        vecs[5] = '{a: 16'h0064, b: 16'h00C8, p: 32'h0000_4E20};
        vecs[6] = '{a: 16'hFFF9, b: 16'h0009, p: 32'hFFFF_FFC1};
        vecs[7] = '{a: 16'h3039, b: 16'h0002, p: 32'h0000_6072};

        fv[0] = '{a: 16'h000B, b: 16'hFFFE, p: 32'hFFFF_FFEA};
        fv[1] = '{a: 16'hFED4, b: 16'h012C, p: 32'hFFFE_A070};
        fv[2] = '{a: 16'h0007, b: 16'h0007, p: 32'h0000_0031};
        fv[3] = '{a: 16'hFFFF, b: 16'h4000, p: 32'hFFFF_C000};

        bp[0] = '{a: 16'hFFFE, b: 16'hFFFD, p: 32'h0000_0006};
        bp[1] = '{a: 16'h03E8, b: 16'hFC18, p: 32'hFFF0_BDC0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid",   32'(out_valid), 32'd0);
        check("rst_out_product", out_product,    32'd0);
        check("rst_out_err",     32'(out_err),   32'd0);
        check("rst_mul_start",   32'(mul_start), 32'd0);
        check("rst_mul_data",    32'(mul_data),  32'd0);
        check("rst_mul_clr",     32'(mul_clr),   32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Table-driven single operations
        for (int i = 0; i < 8; i++) begin
            clr0 = n_clr;
            push(vecs[i].a, vecs[i].b);
            wait_result(200, lat);
            check($sformatf("latency[%0d]", i),   32'(lat),          32'(LAT));
            check($sformatf("product[%0d]", i),   out_product,       vecs[i].p);
            check($sformatf("err[%0d]", i),       32'(out_err),      32'd0);
            check($sformatf("bus_start[%0d]", i), 32'(m_start_data), 32'd0);
            check($sformatf("bus_ld_m[%0d]", i),  32'(m_ld_m),       32'(vecs[i].a));
            check($sformatf("bus_ld_q[%0d]", i),  32'(m_ld_q),       32'(vecs[i].b));
            check($sformatf("clr_pulses[%0d]", i), 32'(n_clr - clr0), 32'd1);
            check($sformatf("bus_idle[%0d]", i),  32'(mul_data),     32'd0);
            handshake();
            check($sformatf("valid_drop[%0d]", i), 32'(out_valid),   32'd0);
        end

        // Back-to-back pushes past FIFO capacity with the multiplier busy
        got_q.delete();
        n_ready_low = 0;
        out_ready   = 1'b1;
        chk_occ     = 1'b1;
        for (int j = 0; j < 4; j++) push(fv[j].a, fv[j].b);
        bad = 0;
        while (got_q.size() < 4 && bad < 500) begin
            @(posedge clk);
            #1;
            bad++;
        end
        chk_occ   = 1'b0;
        out_ready = 1'b0;
        check("fifo_result_count", 32'(got_q.size()), 32'd4);
        check("fifo_saw_full",     32'(n_ready_low > 0), 32'd1);
        for (int j = 0; j < 4 && j < got_q.size(); j++) begin
            check($sformatf("fifo_order[%0d]", j), got_q[j], fv[j].p);
        end

        // Backpressure: result held 20 cycles, next op starts one cycle after handshake
        push(bp[0].a, bp[0].b);
        push(bp[1].a, bp[1].b);
        wait_result(200, lat);
        check("bp_first_product", out_product, bp[0].p);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (!out_valid || out_product !== bp[0].p || mul_start) bad++;
        end
        check("bp_hold_stable", 32'(bad), 32'd0);
        handshake();
        check("bp_valid_drop",     32'(out_valid), 32'd0);
        check("bp_no_start_yet",   32'(mul_start), 32'd0);
        @(posedge clk);
        #1;
        check("bp_next_start",     32'(mul_start), 32'd1);
        wait_result(200, lat);
        check("bp_second_product", out_product, bp[1].p);
        handshake();

        // Asynchronous reset in WAIT with further pairs queued
        push(16'h0005, 16'h0005);
        push(16'h0006, 16'h0006);
        push(16'h0007, 16'h0007);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid",   32'(out_valid), 32'd0);
        check("arst_out_product", out_product,    32'd0);
        check("arst_out_err",     32'(out_err),   32'd0);
        check("arst_mul_start",   32'(mul_start), 32'd0);
        check("arst_mul_data",    32'(mul_data),  32'd0);
        check("arst_mul_clr",     32'(mul_clr),   32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        stale = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (out_valid || mul_start) stale++;
        end
        check("arst_no_stale", 32'(stale), 32'd0);

        // Recovery after reset
        push(vecs[0].a, vecs[0].b);
        wait_result(200, lat);
        check("post_rst_latency", 32'(lat),     32'(LAT));
        check("post_rst_product", out_product,  vecs[0].p);
        handshake();

`ifdef BOOTH_SEQ_TIMEOUT_EN
        // Multiplier never finishes: timeout result after TIMEOUT+1 cycles from WAIT entry
        m_hang = 1'b1;
        clr0   = n_clr;
        push(16'h0009, 16'h0009);
        wait_result(400, lat);
        check("to_latency",    32'(lat),          32'(1 + 3 + TIMEOUT + 1));
        check("to_err",        32'(out_err),      32'd1);
        check("to_product",    out_product,       32'd0);
        check("to_clr_pulses", 32'(n_clr - clr0), 32'd1);
        handshake();
        check("to_err_cleared", 32'(out_err), 32'd0);
        m_hang = 1'b0;
        push(vecs[6].a, vecs[6].b);
        wait_result(200, lat);
        check("to_recover_product", out_product,  vecs[6].p);
        check("to_recover_err",     32'(out_err), 32'd0);
        handshake();
`endif

        check("mul_protocol", 32'(m_proto_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete, %0d vectors applied", n_vec);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/booth_operand_sequencer.md
# booth_operand_sequencer

Upstream/downstream wrapper for the 16-bit sequential Booth multiplier. Accepts signed operand pairs over a valid/ready handshake, buffers them in a small FIFO, and time-multiplexes each pair onto the multiplier's single shared data bus. It pulses start, waits for done, and captures the 32-bit product. Results leave over a second valid/ready handshake, so the multiplier can sit on a streaming datapath.

## Interface
Parameters:
- DEPTH, 2: operand-pair FIFO entries; power of two, 2..8.
- TIMEOUT, 40: maximum cycles to wait for mul_done; used only with the timeout feature.

Ports:
- clk  in  1  rising-edge clock, single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  FIFO not full.
- in_a  in  16  signed multiplicand.
- in_b  in  16  signed multiplier.
- out_valid  out  1  product held.
- out_ready  in  1  consumer accepts.
- out_product  out  32  signed product, {A,Q} order.
- out_err  out  1  product is invalid because of a timeout; forced 0 without the feature.
- mul_start  out  1  start request to the multiplier.
- mul_data  out  16  shared load bus to the multiplier.
- mul_done  in  1  multiplier finished; level, held until mul_clr.
- mul_product  in  32  multiplier result.
- mul_clr  out  1  one-cycle pulse returning the multiplier to its idle/clear state.

## Operation
- The FIFO has DEPTH entries of {in_a, in_b}.
  - Write on in_valid && in_ready.
  - Pop when the FSM leaves IDLE.
  - Pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH.
  - Full and empty are decided by MSB compare.
  - A simultaneous push and pop while full is not allowed: in_ready=0 when full, even if a pop occurs that cycle.
- FSM states: IDLE, START, LD_M, LD_Q, WAIT, RESP, CLR.
  - IDLE: if the FIFO is non-empty and out_valid=0, pop the head into the op_a/op_b registers and go to START.
  - START: mul_start=1 and mul_data=0. Go to LD_M.
  - LD_M: mul_data=op_a. Go to LD_Q.
  - LD_Q: mul_data=op_b. Go to WAIT.
  - WAIT: if mul_done=1, capture out_product<=mul_product and go to CLR. With the timeout feature, a timeout also goes to CLR (see Configuration).
  - CLR: mul_clr=1 for exactly one cycle; out_valid<=1. Go to RESP.
  - RESP: hold until out_valid && out_ready, then clear out_valid and go to IDLE.
- mul_data is 0 in every state other than LD_M and LD_Q.
- out_product and out_err are stable while out_valid=1.
- Only one multiplication is in flight at a time. The FIFO keeps accepting during a multiplication until it is full.

## Timing
- Reset (rst_n=0, asynchronous), all registers clear immediately:
  - state=IDLE.
  - FIFO pointers=0, so in_ready=1 once reset releases.
  - out_valid=0, out_product=0, out_err=0.
  - mul_start=0, mul_data=0, mul_clr=0.
- Reset mid-operation discards the FIFO contents and the in-flight pair; no result is produced.
- Load sequence: START, LD_M and LD_Q are three consecutive cycles.
  - The multiplier samples start in START.
  - It loads the multiplicand at the edge ending LD_M.
  - It loads the multiplier at the edge ending LD_Q.
- Latency from the push of a pair into an empty FIFO to out_valid=1 is 1 (IDLE) + 3 + N + 1 cycles.
  - N is the number of WAIT cycles until mul_done is seen. N≈33 for 16-bit Booth.
- The FIFO is registered: in_ready reflects the current occupancy, with no combinational path from out_ready.
- Back-to-back throughput is one result per (6+N) cycles when out_ready=1 is held.

## Configuration
- Macro BOOTH_SEQ_TIMEOUT_EN.
- Defined:
  - A 6-bit wait counter clears on entry to WAIT and increments each WAIT cycle.
  - When the count reaches TIMEOUT without mul_done, go to CLR with out_err<=1 and out_product<=0.
  - out_err clears on the next result handshake.
- Undefined:
  - There is no counter; WAIT lasts indefinitely.
  - out_err is tied to 0.

## Test plan
- After reset, push a=3, b=-5. Require the START/LD_M/LD_Q bus values 0, 3, -5 on consecutive cycles, then out_product=-15 (0xFFFFFFF1) with out_err=0.
- Corner operands: a=-32768, b=-32768 → 0x40000000; a=32767, b=-1 → 0xFFFF8001; a=0, b=1234 → 0.
- Push DEPTH+1 pairs back-to-back with the multiplier running. Require in_ready=0 exactly when the FIFO is full, no pair lost, and results in push order.
- Hold out_ready=0 for 20 cycles after out_valid. Require the product stable, no new mul_start, and the next op to start 1 cycle after the handshake.
- With BOOTH_SEQ_TIMEOUT_EN defined, never assert mul_done. Require out_valid with out_err=1 and out_product=0 at TIMEOUT+1 cycles after WAIT entry, plus one mul_clr pulse.
- Drop rst_n during WAIT. Require all outputs to clear asynchronously, in_ready=1 after release, and no stale result.
